// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: N-master to single-slave bus arbiter, one access in flight.
// A requester is chosen combinationally and routed to the slave in the same
// cycle. If the slave stalls, the grant is locked until ready_in arrives, the
// master withdraws its request, or the optional wait timeout fires.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   m_*_in                per-master request fields (master i at slice i)
//   m_read_value_out      slave read data broadcast to all masters
//   m_ready_out/fault_out per-master completion / fault
//   address_out..write_value_out  routed slave request (zero when unrouted)
//   read_value_in, ready_in, fault_in  slave response
//   grant_out             one-hot routed master, zero when nothing routed
//   busy_out              high while a stalled access is locked
module bus_arbiter_rr #(
    parameter int unsigned NUM_MASTERS    = 2,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ROUND_ROBIN    = 1,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]     m_address_in,
    input  logic [NUM_MASTERS-1:0]                m_read_in,
    input  logic [NUM_MASTERS-1:0]                m_write_in,
    input  logic [NUM_MASTERS*(DATA_WIDTH/8)-1:0] m_write_mask_in,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]     m_write_value_in,
    output logic [DATA_WIDTH-1:0]                 m_read_value_out,
    output logic [NUM_MASTERS-1:0]                m_ready_out,
    output logic [NUM_MASTERS-1:0]                m_fault_out,
    output logic [ADDR_WIDTH-1:0]                 address_out,
    output logic                                  read_out,
    output logic                                  write_out,
    output logic [(DATA_WIDTH/8)-1:0]             write_mask_out,
    output logic [DATA_WIDTH-1:0]                 write_value_out,
    input  logic [DATA_WIDTH-1:0]                 read_value_in,
    input  logic                                  ready_in,
    input  logic                                  fault_in,
    output logic [NUM_MASTERS-1:0]                grant_out,
    output logic                                  busy_out
);

    localparam int unsigned MW = DATA_WIDTH / 8;
    localparam int unsigned IW = $clog2(NUM_MASTERS);
    localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state, next_state;
    logic [IW-1:0]   last_winner, next_last;
    logic [IW-1:0]   locked_grant, next_locked;
    logic [CW-1:0]   wait_cnt, next_cnt;

    logic [NUM_MASTERS-1:0] req;
    logic                   winner_valid;
    logic [IW-1:0]          winner_idx;

    logic                   route_valid;
    logic [IW-1:0]          route_idx;
    logic                   kill_req;
    logic                   cplt;
    logic                   cplt_fault;
    logic [NUM_MASTERS-1:0] route_onehot;

    assign req = m_read_in | m_write_in;

    // Winner search: rotating from last_winner+1, or lowest index first.
    always_comb begin
        int unsigned cand;
        cand         = 0;
        winner_valid = 1'b0;
        winner_idx   = '0;
        for (int unsigned off = 1; off <= NUM_MASTERS; off++) begin
            if (ROUND_ROBIN != 0)
                cand = (32'(last_winner) + off) % NUM_MASTERS;
            else
                cand = off - 1;
            if (!winner_valid && req[IW'(cand)]) begin
                winner_valid = 1'b1;
                winner_idx   = IW'(cand);
            end
        end
    end

    // Next-state and routing decisions. While reset is held nothing is routed.
    always_comb begin
        next_state  = state;
        next_last   = last_winner;
        next_locked = locked_grant;
        next_cnt    = wait_cnt;
        route_valid = 1'b0;
        route_idx   = '0;
        kill_req    = 1'b0;
        cplt        = 1'b0;
        cplt_fault  = 1'b0;
        if (reset_n) begin
            case (state)
                IDLE: begin
                    if (winner_valid) begin
                        route_valid = 1'b1;
                        route_idx   = winner_idx;
                        if (ready_in) begin
                            cplt       = 1'b1;
                            cplt_fault = fault_in;
                            next_last  = winner_idx;
                        end else begin
                            next_state  = BUSY;
                            next_locked = winner_idx;
                            next_cnt    = CW'(1);
                        end
                    end
                end
                BUSY: begin
                    route_valid = 1'b1;
                    route_idx   = locked_grant;
                    if (ready_in) begin
                        // Slave response beats a simultaneous timeout.
                        cplt       = 1'b1;
                        cplt_fault = fault_in;
                        next_state = IDLE;
                        next_last  = locked_grant;
                        next_cnt   = '0;
                    end else if (!req[locked_grant]) begin
                        // Master withdrew: abort silently, priority unchanged.
                        kill_req   = 1'b1;
                        next_state = IDLE;
                        next_cnt   = '0;
                    end else if ((TIMEOUT_CYCLES > 0) && (wait_cnt == CW'(TIMEOUT_CYCLES))) begin
                        kill_req   = 1'b1;
                        cplt       = 1'b1;
                        cplt_fault = 1'b1;
                        next_state = IDLE;
                        next_last  = locked_grant;
                        next_cnt   = '0;
                    end else if (wait_cnt != {CW{1'b1}}) begin
                        next_cnt = wait_cnt + CW'(1);
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            last_winner  <= IW'(NUM_MASTERS - 1);
            locked_grant <= '0;
            wait_cnt     <= '0;
        end else begin
            state        <= next_state;
            last_winner  <= next_last;
            locked_grant <= next_locked;
            wait_cnt     <= next_cnt;
        end
    end

    assign route_onehot = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << route_idx;

    // Slave-side routing, zeroed when nothing is routed.
    assign address_out     = route_valid ? m_address_in[32'(route_idx)*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    assign write_mask_out  = route_valid ? m_write_mask_in[32'(route_idx)*MW +: MW] : '0;
    assign write_value_out = route_valid ? m_write_value_in[32'(route_idx)*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign read_out        = route_valid && !kill_req && m_read_in[route_idx];
    assign write_out       = route_valid && !kill_req && m_write_in[route_idx];

    // Master-side responses.
    assign grant_out        = route_valid ? route_onehot : '0;
    assign m_ready_out      = cplt ? route_onehot : '0;
    assign m_fault_out      = (cplt && cplt_fault) ? route_onehot : '0;
    assign m_read_value_out = read_value_in;
    assign busy_out         = (state == BUSY);

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench: a rotating-priority arbiter with a 4-cycle timeout and a
// fixed-priority arbiter without timeout share one set of master stimuli.
module tb_bus_arbiter_rr;

    localparam int unsigned N  = 4;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned MW = DW / 8;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic [N*AW-1:0] m_address;
    logic [N-1:0]    m_read, m_write;
    logic [N*MW-1:0] m_mask;
    logic [N*DW-1:0] m_wval;
    logic [DW-1:0]   rdata;
    logic            ready, fault;

    logic [DW-1:0] rr_rval, fx_rval;
    logic [N-1:0]  rr_mr, rr_mf, rr_g, fx_mr, fx_mf, fx_g;
    logic [AW-1:0] rr_addr, fx_addr;
    logic          rr_rd, rr_wr, fx_rd, fx_wr, rr_busy, fx_busy;
    logic [MW-1:0] rr_mask, fx_mask;
    logic [DW-1:0] rr_wv, fx_wv;

    bus_arbiter_rr #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                     .ROUND_ROBIN(1), .TIMEOUT_CYCLES(4)) dut_rr (
        .clk(clk), .reset_n(reset_n),
        .m_address_in(m_address), .m_read_in(m_read), .m_write_in(m_write),
        .m_write_mask_in(m_mask), .m_write_value_in(m_wval),
        .m_read_value_out(rr_rval), .m_ready_out(rr_mr), .m_fault_out(rr_mf),
        .address_out(rr_addr), .read_out(rr_rd), .write_out(rr_wr),
        .write_mask_out(rr_mask), .write_value_out(rr_wv),
        .read_value_in(rdata), .ready_in(ready), .fault_in(fault),
        .grant_out(rr_g), .busy_out(rr_busy));

    bus_arbiter_rr #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                     .ROUND_ROBIN(0), .TIMEOUT_CYCLES(0)) dut_fx (
        .clk(clk), .reset_n(reset_n),
        .m_address_in(m_address), .m_read_in(m_read), .m_write_in(m_write),
        .m_write_mask_in(m_mask), .m_write_value_in(m_wval),
        .m_read_value_out(fx_rval), .m_ready_out(fx_mr), .m_fault_out(fx_mf),
        .address_out(fx_addr), .read_out(fx_rd), .write_out(fx_wr),
        .write_mask_out(fx_mask), .write_value_out(fx_wv),
        .read_value_in(rdata), .ready_in(ready), .fault_in(fault),
        .grant_out(fx_g), .busy_out(fx_busy));

    typedef struct {
        logic       fx;
        logic [3:0] rd, wr;
        logic       rdy, flt;
        logic [3:0] g, mr, mf;
        logic       bsy, ro, wo;
    } vec_t;

    vec_t vecs[$];
    int   tests  = 0;
    int   failed = 0;

    function automatic vec_t mk(logic fx, logic [3:0] rd, logic [3:0] wr, logic rdy, logic flt,
                                logic [3:0] g, logic [3:0] mr, logic [3:0] mf,
                                logic bsy, logic ro, logic wo);
        vec_t t;
        t.fx = fx; t.rd = rd; t.wr = wr; t.rdy = rdy; t.flt = flt;
        t.g = g; t.mr = mr; t.mf = mf; t.bsy = bsy; t.ro = ro; t.wo = wo;
        return t;
    endfunction

    // Reference payload for each master.
    function automatic logic [31:0] ref_addr(int i);
        return (i == 0) ? 32'h100 : 32'h1000 + 32'(i) * 32'h10;
    endfunction
    function automatic logic [31:0] ref_wval(int i);
        return (i == 0) ? 32'hDEADBEEF : 32'hA000_0000 + 32'(i);
    endfunction
    function automatic logic [3:0] ref_mask(int i);
        return (i == 0) ? 4'hF : 4'(i);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t t, input int n);
        logic [3:0]  g, mr, mf;
        logic        bsy, ro, wo;
        logic [31:0] addr, wv, ea, ew;
        logic [3:0]  msk, em;
        @(posedge clk); #1;
        m_read = t.rd; m_write = t.wr; ready = t.rdy; fault = t.flt;
        @(negedge clk);
        g   = t.fx ? fx_g    : rr_g;
        mr  = t.fx ? fx_mr   : rr_mr;
        mf  = t.fx ? fx_mf   : rr_mf;
        bsy = t.fx ? fx_busy : rr_busy;
        ro  = t.fx ? fx_rd   : rr_rd;
        wo  = t.fx ? fx_wr   : rr_wr;
        addr = t.fx ? fx_addr : rr_addr;
        wv   = t.fx ? fx_wv   : rr_wv;
        msk  = t.fx ? fx_mask : rr_mask;
        ea = '0; ew = '0; em = '0;
        for (int i = 0; i < 4; i++)
            if (t.g[i]) begin ea = ref_addr(i); ew = ref_wval(i); em = ref_mask(i); end
        check($sformatf("v%0d grant", n), 64'(g), 64'(t.g));
        check($sformatf("v%0d m_ready", n), 64'(mr), 64'(t.mr));
        check($sformatf("v%0d m_fault", n), 64'(mf), 64'(t.mf));
        check($sformatf("v%0d busy", n), 64'(bsy), 64'(t.bsy));
        check($sformatf("v%0d read_out", n), 64'(ro), 64'(t.ro));
        check($sformatf("v%0d write_out", n), 64'(wo), 64'(t.wo));
        check($sformatf("v%0d address", n), 64'(addr), 64'(ea));
        check($sformatf("v%0d wvalue", n), 64'(wv), 64'(ew));
        check($sformatf("v%0d wmask", n), 64'(msk), 64'(em));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            m_address[i*AW +: AW] = ref_addr(i);
            m_wval[i*DW +: DW]    = ref_wval(i);
            m_mask[i*MW +: MW]    = ref_mask(i);
        end
        rdata = 32'h5A5A_1234;
        m_read = 4'b1111; m_write = '0; ready = 1'b1; fault = 1'b0;
        reset_n = 1'b0;

        // Rotating-priority sequence (rows 0..23), then fixed-priority (24..).
        //               fx  rd       wr       rdy  flt  grant    ready    fault    bsy  ro   wo
        vecs.push_back(mk(0, 4'b0011, 4'b0000, 1, 0, 4'b0001, 4'b0001, 4'b0000, 0, 1, 0));
        vecs.push_back(mk(0, 4'b0011, 4'b0000, 1, 0, 4'b0010, 4'b0010, 4'b0000, 0, 1, 0));
        vecs.push_back(mk(0, 4'b0011, 4'b0000, 1, 0, 4'b0001, 4'b0001, 4'b0000, 0, 1, 0));
        vecs.push_back(mk(0, 4'b0011, 4'b0000, 1, 0, 4'b0010, 4'b0010, 4'b0000, 0, 1, 0));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0));
        vecs.push_back(mk(0, 4'b0100, 4'b0000, 0, 0, 4'b0100, 4'b0000, 4'b0000, 0, 1, 0));
        vecs.push_back(mk(0, 4'b0100, 4'b0000, 0, 0, 4'b0100, 4'b0000, 4'b0000, 1, 1, 0));
        vecs.push_back(mk(0, 4'b0100, 4'b0000, 0, 0, 4'b0100, 4'b0000, 4'b0000, 1, 1, 0));
        vecs.push_back(mk(0, 4'b0100, 4'b0000, 0, 0, 4'b0100, 4'b0000, 4'b0000, 1, 1, 0));
        vecs.push_back(mk(0, 4'b0100, 4'b0000, 0, 0, 4'b0100, 4'b0100, 4'b0100, 1, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0));
        vecs.push_back(mk(0, 4'b1011, 4'b0000, 1, 0, 4'b1000, 4'b1000, 4'b0000, 0, 1, 0));
        vecs.push_back(mk(0, 4'b0011, 4'b0000, 1, 0, 4'b0001, 4'b0001, 4'b0000, 0, 1, 0));
        vecs.push_back(mk(0, 4'b0000, 4'b0001, 0, 0, 4'b0001, 4'b0000, 4'b0000, 0, 0, 1));
        vecs.push_back(mk(0, 4'b0000, 4'b0001, 1, 1, 4'b0001, 4'b0001, 4'b0001, 1, 0, 1));
        vecs.push_back(mk(0, 4'b0010, 4'b0000, 0, 0, 4'b0010, 4'b0000, 4'b0000, 0, 1, 0));
        vecs.push_back(mk(0, 4'b0010, 4'b0000, 0, 0, 4'b0010, 4'b0000, 4'b0000, 1, 1, 0));
        vecs.push_back(mk(0, 4'b0010, 4'b0000, 0, 0, 4'b0010, 4'b0000, 4'b0000, 1, 1, 0));
        vecs.push_back(mk(0, 4'b0010, 4'b0000, 0, 0, 4'b0010, 4'b0000, 4'b0000, 1, 1, 0));
        vecs.push_back(mk(0, 4'b0010, 4'b0000, 1, 0, 4'b0010, 4'b0010, 4'b0000, 1, 1, 0));
        vecs.push_back(mk(0, 4'b0101, 4'b0000, 0, 0, 4'b0100, 4'b0000, 4'b0000, 0, 1, 0));
        vecs.push_back(mk(0, 4'b0001, 4'b0000, 0, 0, 4'b0100, 4'b0000, 4'b0000, 1, 0, 0));
        vecs.push_back(mk(0, 4'b0001, 4'b0000, 1, 0, 4'b0001, 4'b0001, 4'b0000, 0, 1, 0));
        vecs.push_back(mk(0, 4'b1000, 4'b1000, 1, 0, 4'b1000, 4'b1000, 4'b0000, 0, 1, 1));
        vecs.push_back(mk(1, 4'b1010, 4'b0000, 0, 0, 4'b0010, 4'b0000, 4'b0000, 0, 1, 0));
        vecs.push_back(mk(1, 4'b1010, 4'b0000, 0, 0, 4'b0010, 4'b0000, 4'b0000, 1, 1, 0));
        vecs.push_back(mk(1, 4'b1010, 4'b0000, 0, 0, 4'b0010, 4'b0000, 4'b0000, 1, 1, 0));
        vecs.push_back(mk(1, 4'b1010, 4'b0000, 1, 0, 4'b0010, 4'b0010, 4'b0000, 1, 1, 0));
        vecs.push_back(mk(1, 4'b1000, 4'b0000, 1, 0, 4'b1000, 4'b1000, 4'b0000, 0, 1, 0));
        vecs.push_back(mk(1, 4'b1111, 4'b0000, 1, 0, 4'b0001, 4'b0001, 4'b0000, 0, 1, 0));
        vecs.push_back(mk(1, 4'b1110, 4'b0000, 1, 0, 4'b0010, 4'b0010, 4'b0000, 0, 1, 0));
        vecs.push_back(mk(1, 4'b0000, 4'b0000, 1, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0));

        // Reset state with requests pending: nothing routed.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset rr busy", 64'(rr_busy), 64'(0));
        check("reset rr grant", 64'(rr_g), 64'(0));
        check("reset rr m_ready", 64'(rr_mr), 64'(0));
        check("reset rr read_out", 64'(rr_rd), 64'(0));
        check("reset fx grant", 64'(fx_g), 64'(0));
        check("reset fx busy", 64'(fx_busy), 64'(0));
        check("read data broadcast", 64'(rr_rval), 64'(32'h5A5A_1234));
        m_read = '0;
        reset_n = 1'b1;

        for (int n = 0; n < 24; n++) run_vec(vecs[n], n);

        // Reset asserted while a stalled access is locked.
        run_vec(mk(0, 4'b0001, 4'b0000, 0, 0, 4'b0001, 4'b0000, 4'b0000, 0, 1, 0), 100);
        @(posedge clk); #1;
        check("pre-reset busy", 64'(rr_busy), 64'(1));
        check("pre-reset grant", 64'(rr_g), 64'(4'b0001));
        reset_n = 1'b0;
        #1;
        check("mid-busy reset busy", 64'(rr_busy), 64'(0));
        check("mid-busy reset grant", 64'(rr_g), 64'(0));
        check("mid-busy reset m_ready", 64'(rr_mr), 64'(0));
        check("mid-busy reset read_out", 64'(rr_rd), 64'(0));
        m_read = '0;
        @(negedge clk);
        reset_n = 1'b1;
        run_vec(mk(0, 4'b0011, 4'b0000, 1, 0, 4'b0001, 4'b0001, 4'b0000, 0, 1, 0), 101);

        for (int n = 24; n < vecs.size(); n++) run_vec(vecs[n], n);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
